fsram_ctrl: RTL and testbench

//  Sequencer for the fsram feature-map buffer (SRAM_NUM dual-port banks, port A on clk, port B on ~clk).

---
 rtl/fsram_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_fsram_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsram_ctrl.sv
// fsram_ctrl: write/read sequencer for the fsram feature-map buffer.
// Port A writes on clk, port B reads on ~clk, all SRAM pins registered.
module fsram_ctrl #(
    parameter int SRAM_NUM = 8,
    parameter int AW       = 11,
    parameter int DW       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_start,
    input  logic [AW-1:0]          wr_base,
    input  logic [AW:0]            wr_len,
    input  logic [SRAM_NUM-1:0]    wr_mask,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SRAM_NUM*DW-1:0] in_data,
    output logic                   wr_busy,
    output logic                   wr_done,
    input  logic                   rd_start,
    input  logic [AW-1:0]          rd_base,
    input  logic [AW:0]            rd_len,
    output logic                   out_valid,
    output logic [SRAM_NUM*DW-1:0] out_data,
    output logic                   rd_busy,
    output logic                   rd_done,
    output logic                   CENA,
    output logic [SRAM_NUM-1:0]    WENA,
    output logic [SRAM_NUM*AW-1:0] AA,
    output logic [SRAM_NUM*DW-1:0] DA,
    output logic                   CENB,
    output logic [SRAM_NUM-1:0]    WENB,
    output logic [SRAM_NUM*AW-1:0] AB,
    output logic [SRAM_NUM*DW-1:0] DB,
    input  logic [SRAM_NUM*DW-1:0] QB
);

    localparam int NW = SRAM_NUM * DW;
    localparam logic [AW-1:0] ONE_A = 1;
    localparam logic [AW:0]   ONE_L = 1;

    typedef enum logic { W_IDLE, W_RUN } w_state_e;
    typedef enum logic { R_IDLE, R_RUN } r_state_e;

    w_state_e            w_state_q, w_state_d;
    logic [AW-1:0]       w_addr_q, w_addr_d;
    logic [AW:0]         w_cnt_q, w_cnt_d;
    logic [AW:0]         w_len_q, w_len_d;
    logic [SRAM_NUM-1:0] w_mask_q, w_mask_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_done_q, wr_done_d;
    logic                cena_q, cena_d;
    logic [SRAM_NUM-1:0] wena_q, wena_d;
    logic [AW-1:0]       aa_q, aa_d;
    logic [NW-1:0]       da_q, da_d;

    r_state_e            r_state_q, r_state_d;
    logic [AW-1:0]       r_addr_q, r_addr_d;
    logic [AW:0]         r_cnt_q, r_cnt_d;
    logic [AW:0]         r_len_q, r_len_d;
    logic                r_last_q, r_last_d;
    logic                cenb_q, cenb_d;
    logic [AW-1:0]       ab_q, ab_d;
    logic                out_valid_q, out_valid_d;
    logic [NW-1:0]       out_data_q, out_data_d;
    logic                rd_done_q, rd_done_d;

    always_comb begin
        w_state_d  = w_state_q;
        w_addr_d   = w_addr_q;
        w_cnt_d    = w_cnt_q;
        w_len_d    = w_len_q;
        w_mask_d   = w_mask_q;
        in_ready_d = in_ready_q;
        wr_done_d  = 1'b0;
        cena_d     = 1'b1;
        wena_d     = '1;
        aa_d       = aa_q;
        da_d       = da_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (wr_start) begin
                    if (wr_len == '0) begin
                        wr_done_d = 1'b1;
                    end else begin
                        w_state_d  = W_RUN;
                        w_addr_d   = wr_base;
                        w_len_d    = wr_len;
                        w_mask_d   = wr_mask;
                        w_cnt_d    = '0;
                        in_ready_d = 1'b1;
                    end
                end
            end
            W_RUN: begin
                if (in_valid && in_ready_q) begin
                    aa_d     = w_addr_q;
                    da_d     = in_data;
                    cena_d   = 1'b0;
                    wena_d   = ~w_mask_q;
                    w_addr_d = w_addr_q + ONE_A;
                    w_cnt_d  = w_cnt_q + ONE_L;
                    if (w_cnt_q + ONE_L == w_len_q) begin
                        w_state_d  = W_IDLE;
                        in_ready_d = 1'b0;
                        wr_done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Data issued last cycle was sampled by port B on the falling edge.
    always_comb begin
        r_state_d   = r_state_q;
        r_addr_d    = r_addr_q;
        r_cnt_d     = r_cnt_q;
        r_len_d     = r_len_q;
        r_last_d    = 1'b0;
        cenb_d      = 1'b1;
        ab_d        = ab_q;
        out_valid_d = ~cenb_q;
        out_data_d  = cenb_q ? out_data_q : QB;
        rd_done_d   = ~cenb_q & r_last_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (rd_start) begin
                    if (rd_len == '0) begin
                        rd_done_d = 1'b1;
                    end else begin
                        ab_d     = rd_base;
                        cenb_d   = 1'b0;
                        r_addr_d = rd_base + ONE_A;
                        r_cnt_d  = ONE_L;
                        r_len_d  = rd_len;
                        if (rd_len == ONE_L) r_last_d = 1'b1;
                        else r_state_d = R_RUN;
                    end
                end
            end
            R_RUN: begin
                ab_d     = r_addr_q;
                cenb_d   = 1'b0;
                r_addr_d = r_addr_q + ONE_A;
                r_cnt_d  = r_cnt_q + ONE_L;
                if (r_cnt_q + ONE_L == r_len_q) begin
                    r_last_d  = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            w_addr_q    <= '0;
            w_cnt_q     <= '0;
            w_len_q     <= '0;
            w_mask_q    <= '0;
            in_ready_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            cena_q      <= 1'b1;
            wena_q      <= '1;
            aa_q        <= '0;
            da_q        <= '0;
            r_state_q   <= R_IDLE;
            r_addr_q    <= '0;
            r_cnt_q     <= '0;
            r_len_q     <= '0;
            r_last_q    <= 1'b0;
            cenb_q      <= 1'b1;
            ab_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rd_done_q   <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            w_addr_q    <= w_addr_d;
            w_cnt_q     <= w_cnt_d;
            w_len_q     <= w_len_d;
            w_mask_q    <= w_mask_d;
            in_ready_q  <= in_ready_d;
            wr_done_q   <= wr_done_d;
            cena_q      <= cena_d;
            wena_q      <= wena_d;
            aa_q        <= aa_d;
            da_q        <= da_d;
            r_state_q   <= r_state_d;
            r_addr_q    <= r_addr_d;
            r_cnt_q     <= r_cnt_d;
            r_len_q     <= r_len_d;
            r_last_q    <= r_last_d;
            cenb_q      <= cenb_d;
            ab_q        <= ab_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_busy   = (w_state_q != W_IDLE);
    assign wr_done   = wr_done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign rd_busy   = (r_state_q != R_IDLE) | ~cenb_q | out_valid_q;
    assign rd_done   = rd_done_q;
    assign CENA      = cena_q;
    assign WENA      = wena_q;
    assign AA        = {SRAM_NUM{aa_q}};
    assign DA        = da_q;
    assign CENB      = cenb_q;
    assign WENB      = '1;
    assign AB        = {SRAM_NUM{ab_q}};
    assign DB        = '0;

endmodule

// File: tb/tb_fsram_ctrl.sv
// tb_fsram_ctrl: directed bench for fsram_ctrl with a behavioural
// dual-port SRAM (port A writes on rising edge, port B reads on falling edge).
module tb_fsram_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_start;
    logic [10:0]  wr_base;
    logic [11:0]  wr_len;
    logic [7:0]   wr_mask;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         wr_busy;
    logic         wr_done;
    logic         rd_start;
    logic [10:0]  rd_base;
    logic [11:0]  rd_len;
    logic         out_valid;
    logic [127:0] out_data;
    logic         rd_busy;
    logic         rd_done;
    logic         CENA;
    logic [7:0]   WENA;
    logic [87:0]  AA;
    logic [127:0] DA;
    logic         CENB;
    logic [7:0]   WENB;
    logic [87:0]  AB;
    logic [127:0] DB;
    logic [127:0] QB = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]  mem [0:7][0:2047];
    logic [127:0] wr_w [16];
    logic [127:0] rd_exp [16];

    fsram_ctrl #(.SRAM_NUM(8), .AW(11), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .wr_start(wr_start), .wr_base(wr_base), .wr_len(wr_len),
        .wr_mask(wr_mask), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr_busy(wr_busy), .wr_done(wr_done),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
        .out_valid(out_valid), .out_data(out_data), .rd_busy(rd_busy),
        .rd_done(rd_done),
        .CENA(CENA), .WENA(WENA), .AA(AA), .DA(DA),
        .CENB(CENB), .WENB(WENB), .AB(AB), .DB(DB), .QB(QB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (!CENA && !WENA[i])
                mem[i][AA[i*11 +: 11]] <= DA[i*16 +: 16];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 8; i++)
            if (!CENB)
                QB[i*16 +: 16] <= mem[i][AB[i*11 +: 11]];
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [15:0] b);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = b + 16'(i);
        return r;
    endfunction

    task automatic wr_burst(input logic [10:0] base, input int len,
                            input logic [7:0] mask);
        int k;
        int g;
        wr_base = base;
        wr_len = 12'(len);
        wr_mask = mask;
        wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        k = 0;
        g = 0;
        while (k < len && g < 200) begin
            in_valid = 1'b1;
            in_data = wr_w[k];
            if (in_ready) k++;
            step();
            g++;
        end
        in_valid = 1'b0;
        check("wr_done", {127'd0, wr_done}, 128'd1);
        step();
    endtask

    task automatic rd_burst(input logic [10:0] base, input int len);
        int n;
        int first;
        int last;
        rd_base = base;
        rd_len = 12'(len);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        check("cenb_issue", {127'd0, CENB}, 128'd0);
        check("ab_issue", {117'd0, AB[10:0]}, {117'd0, base});
        n = 0;
        first = -1;
        last = -1;
        for (int c = 1; c < len + 6; c++) begin
            if (out_valid) begin
                if (first < 0) first = c;
                last = c;
                check("rd_data", out_data, rd_exp[n]);
                check("rd_done", {127'd0, rd_done}, {127'd0, n == len - 1});
                n++;
            end
            step();
        end
        check("rd_lat", 128'(first), 128'd2);
        check("rd_beats", 128'(n), 128'(len));
        check("rd_contig", 128'(last - first + 1), 128'(len));
        check("rd_busy_end", {127'd0, rd_busy}, 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        wr_start = 1'b0;
        wr_base = '0;
        wr_len = '0;
        wr_mask = '0;
        in_valid = 1'b0;
        in_data = '0;
        rd_start = 1'b0;
        rd_base = '0;
        rd_len = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Test 1: reset in the middle of traffic
        wr_base = 11'h300; wr_len = 12'd4; wr_mask = 8'hFF; wr_start = 1'b1;
        rd_base = 11'h300; rd_len = 12'd5; rd_start = 1'b1;
        step();
        wr_start = 1'b0; rd_start = 1'b0;
        in_valid = 1'b1; in_data = mk(16'h7700);
        step();
        step();
        rst = 1'b1;
        step();
        step();
        step();
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_cena", {127'd0, CENA}, 128'd1);
        check("rst_cenb", {127'd0, CENB}, 128'd1);
        check("rst_wena", {120'd0, WENA}, 128'hFF);
        check("rst_aa", {40'd0, AA}, 128'd0);
        check("rst_da", DA, 128'd0);
        check("rst_ab", {40'd0, AB}, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_busy", {126'd0, wr_busy, rd_busy}, 128'd0);
        check("rst_done", {126'd0, wr_done, rd_done}, 128'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        check("rst_no_done", {126'd0, wr_done, rd_done}, 128'd0);

        // Test 2: wrapping write with a gap after beat 2
        for (int k = 0; k < 4; k++) wr_w[k] = mk(16'h1000 * 16'(k + 1));
        wr_base = 11'h7FE; wr_len = 12'd4; wr_mask = 8'hFF; wr_start = 1'b1;
        step();
        wr_start = 1'b0;
        check("w_ready", {127'd0, in_ready}, 128'd1);
        check("w_busy", {127'd0, wr_busy}, 128'd1);
        check("w_idle_cena", {127'd0, CENA}, 128'd1);
        in_valid = 1'b1; in_data = wr_w[0];
        step();
        check("w0_aa", {40'd0, AA}, {40'd0, {8{11'h7FE}}});
        check("w0_cena", {127'd0, CENA}, 128'd0);
        check("w0_wena", {120'd0, WENA}, 128'h00);
        check("w0_da", DA, wr_w[0]);
        in_data = wr_w[1];
        step();
        check("w1_aa", {117'd0, AA[10:0]}, 128'h7FF);
        check("w1_cena", {127'd0, CENA}, 128'd0);
        in_valid = 1'b0;
        step();
        check("wgap_cena", {127'd0, CENA}, 128'd1);
        check("wgap_wena", {120'd0, WENA}, 128'hFF);
        in_valid = 1'b1; in_data = wr_w[2];
        step();
        check("w2_aa", {117'd0, AA[10:0]}, 128'h000);
        check("w2_cena", {127'd0, CENA}, 128'd0);
        check("w2_done", {127'd0, wr_done}, 128'd0);
        in_data = wr_w[3];
        step();
        in_valid = 1'b0;
        check("w3_aa", {117'd0, AA[87:77]}, 128'h001);
        check("w3_da", DA, wr_w[3]);
        check("w3_done", {127'd0, wr_done}, 128'd1);
        check("w3_ready", {127'd0, in_ready}, 128'd0);
        step();
        check("w_end_done", {127'd0, wr_done}, 128'd0);
        check("w_end_cena", {127'd0, CENA}, 128'd1);

        // Test 3: read back the wrapped burst
        for (int k = 0; k < 4; k++) rd_exp[k] = wr_w[k];
        rd_burst(11'h7FE, 4);

        // Test 4: zero-length bursts
        wr_len = 12'd0; rd_len = 12'd0;
        wr_start = 1'b1; rd_start = 1'b1;
        step();
        wr_start = 1'b0; rd_start = 1'b0;
        check("z_done", {126'd0, wr_done, rd_done}, 128'd3);
        check("z_cen", {126'd0, CENA, CENB}, 128'd3);
        check("z_busy", {126'd0, wr_busy, rd_busy}, 128'd0);
        step();
        check("z_done_off", {126'd0, wr_done, rd_done}, 128'd0);
        check("z_cen2", {126'd0, CENA, CENB}, 128'd3);

        // Test 5: masked overwrite
        wr_w[0] = {8{16'h5555}};
        wr_burst(11'h100, 1, 8'hFF);
        wr_w[0] = {8{16'hAAAA}};
        wr_burst(11'h100, 1, 8'h0F);
        rd_exp[0] = {{4{16'h5555}}, {4{16'hAAAA}}};
        rd_burst(11'h100, 1);

        // Test 6: reset during a read, then a clean re-read
        for (int k = 0; k < 6; k++) begin
            wr_w[k] = mk(16'h6000 + 16'(k) * 16'h0100);
            rd_exp[k] = wr_w[k];
        end
        wr_burst(11'h200, 6, 8'hFF);
        rd_base = 11'h200; rd_len = 12'd6; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        check("r6_b0_valid", {127'd0, out_valid}, 128'd1);
        check("r6_b0_data", out_data, rd_exp[0]);
        step();
        check("r6_b1_data", out_data, rd_exp[1]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("r6_rst_valid", {127'd0, out_valid}, 128'd0);
        check("r6_rst_done", {127'd0, rd_done}, 128'd0);
        check("r6_rst_busy", {127'd0, rd_busy}, 128'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("r6_quiet", {126'd0, out_valid, rd_done}, 128'd0);
        end
        rd_burst(11'h200, 6);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
